// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the stage sequencer, instruction memory and the LC3 control decoder.
// master = sequencer side, slave = memory/control side.
interface stage_sequencer_if;
  logic        fetch_req;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic [1:0]  stage;
  logic [15:0] instruction;
  logic        stage_valid;
  logic        next_stage_le;
  logic [1:0]  next_stage;

  modport master (
    output fetch_req, stage, instruction, stage_valid,
    input  mem_ready, mem_data, next_stage_le, next_stage
  );

  modport slave (
    input  fetch_req, stage, instruction, stage_valid,
    output mem_ready, mem_data, next_stage_le, next_stage
  );
endinterface

// File: rtl/stage_sequencer.sv
// Fetches LC3 instruction words and steps the control stage counter 0..3 (or jumps on request),
// stopping on HALT (TRAP x25) or a fetch timeout and counting retired instructions.
module stage_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  stage_sequencer_if.master      bus,
  output logic                   halted,
  output logic                   fault,
  output logic [COUNT_W-1:0]     instr_count
);

  localparam logic [15:0] HALT_WORD = 16'hF025;
  localparam int          TW        = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {IDLE, FETCH_WAIT, EXEC, STOP} state_t;

  state_t               state, state_nx;
  logic [1:0]           stage_q, stage_nx;
  logic [15:0]          instr_q, instr_nx;
  logic                 valid_q, valid_nx;
  logic                 req_q, req_nx;
  logic                 halted_q, halted_nx;
  logic                 fault_q, fault_nx;
  logic [COUNT_W-1:0]   count_q, count_nx;
  logic [TW-1:0]        tmo_q, tmo_nx;
  logic [TW-1:0]        tmo_inc;
  logic                 retire;

  assign bus.stage       = stage_q;
  assign bus.instruction = instr_q;
  assign bus.stage_valid = valid_q;
  assign bus.fetch_req   = req_q;
  assign halted          = halted_q;
  assign fault           = fault_q;
  assign instr_count     = count_q;
  assign tmo_inc         = tmo_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      stage_q  <= 2'd0;
      instr_q  <= 16'h0000;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      count_q  <= '0;
      tmo_q    <= '0;
    end else begin
      state    <= state_nx;
      stage_q  <= stage_nx;
      instr_q  <= instr_nx;
      valid_q  <= valid_nx;
      req_q    <= req_nx;
      halted_q <= halted_nx;
      fault_q  <= fault_nx;
      count_q  <= count_nx;
      tmo_q    <= tmo_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    stage_nx  = stage_q;
    instr_nx  = instr_q;
    valid_nx  = valid_q;
    req_nx    = req_q;
    halted_nx = halted_q;
    fault_nx  = fault_q;
    count_nx  = count_q;
    tmo_nx    = tmo_q;
    retire    = 1'b0;

    case (state)
      IDLE: begin
        if (run) begin
          state_nx = FETCH_WAIT;
          req_nx   = 1'b1;
        end
      end

      // A word arriving on the last allowed cycle beats the timeout.
      FETCH_WAIT: begin
        if (bus.mem_ready) begin
          instr_nx = bus.mem_data;
          req_nx   = 1'b0;
          stage_nx = 2'd0;
          valid_nx = 1'b1;
          tmo_nx   = '0;
          state_nx = EXEC;
        end else if (MEM_TIMEOUT != 0) begin
          tmo_nx = tmo_inc;
          if (tmo_inc == TMO_LIMIT) begin
            fault_nx = 1'b1;
            req_nx   = 1'b0;
            state_nx = STOP;
          end
        end
      end

      EXEC: begin
        retire = bus.next_stage_le ? (bus.next_stage == 2'd0) : (stage_q == 2'd3);
        if (retire) begin
          count_nx = count_q + 1'b1;
          stage_nx = 2'd0;
          valid_nx = 1'b0;
          if (instr_q == HALT_WORD) begin
            halted_nx = 1'b1;
            state_nx  = STOP;
          end else if (run) begin
            req_nx   = 1'b1;
            state_nx = FETCH_WAIT;
          end else begin
            state_nx = IDLE;
          end
        end else if (bus.next_stage_le) begin
          stage_nx = bus.next_stage;
        end else begin
          stage_nx = stage_q + 2'd1;
        end
      end

      STOP: begin
        valid_nx = 1'b0;
        req_nx   = 1'b0;
        stage_nx = 2'd0;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized bench for stage_sequencer: a transaction-level model tracks fetch/stage/retire progress
// and is compared every cycle, with directed scenarios pinning hand-computed values.
module tb_stage_sequencer;
  localparam int TO = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          halted;
  logic          fault;
  logic [CW-1:0] instr_count;

  stage_sequencer_if bus();

  stage_sequencer #(.MEM_TIMEOUT(TO), .COUNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .bus(bus),
    .halted(halted),
    .fault(fault),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Model state: what the block is doing, not how the RTL encodes it.
  bit          m_fetching;
  bit          m_running;
  bit          m_stopped;
  bit          m_halted;
  bit          m_fault;
  int          m_stage;
  int          m_wait;
  int          m_retired;
  logic [15:0] m_instr;

  task automatic check_literal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_fetching = 0; m_running = 0; m_stopped = 0; m_halted = 0; m_fault = 0;
    m_stage = 0; m_wait = 0; m_retired = 0; m_instr = 16'h0000;
  endtask

  task automatic model_step();
    bit retire;
    if (rst) begin
      model_clear();
    end else if (m_stopped) begin
      m_fetching = 0;
    end else if (m_fetching) begin
      if (bus.mem_ready) begin
        m_instr = bus.mem_data;
        m_fetching = 0;
        m_running = 1;
        m_stage = 0;
        m_wait = 0;
      end else begin
        m_wait++;
        if (TO != 0 && m_wait == TO) begin
          m_fault = 1;
          m_stopped = 1;
          m_fetching = 0;
        end
      end
    end else if (m_running) begin
      retire = bus.next_stage_le ? (bus.next_stage == 2'd0) : (m_stage == 3);
      if (retire) begin
        m_retired++;
        m_running = 0;
        m_stage = 0;
        if (m_instr == 16'hF025) begin
          m_halted = 1;
          m_stopped = 1;
        end else if (run) begin
          m_fetching = 1;
        end
      end else begin
        m_stage = bus.next_stage_le ? int'(bus.next_stage) : m_stage + 1;
      end
    end else if (run) begin
      m_fetching = 1;
    end
  endtask

  task automatic check_output();
    check_literal("model_stage", 32'(bus.stage), 32'(m_running ? m_stage : 0));
    check_literal("model_stage_valid", 32'(bus.stage_valid), 32'(m_running));
    check_literal("model_fetch_req", 32'(bus.fetch_req), 32'(m_fetching));
    check_literal("model_instruction", 32'(bus.instruction), 32'(m_instr));
    check_literal("model_halted", 32'(halted), 32'(m_halted));
    check_literal("model_fault", 32'(fault), 32'(m_fault));
    check_literal("model_instr_count", 32'(instr_count), 32'(m_retired % (1 << CW)));
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) if (check_en) check_output();

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic r, input logic ready, input logic [15:0] data,
                                input logic le, input logic [1:0] ns);
    run               = r;
    bus.mem_ready     = ready;
    bus.mem_data      = data;
    bus.next_stage_le = le;
    bus.next_stage    = ns;
  endtask

  task automatic check_reset(input string tag);
    check_literal({tag, "_stage"}, 32'(bus.stage), 0);
    check_literal({tag, "_instruction"}, 32'(bus.instruction), 0);
    check_literal({tag, "_stage_valid"}, 32'(bus.stage_valid), 0);
    check_literal({tag, "_fetch_req"}, 32'(bus.fetch_req), 0);
    check_literal({tag, "_halted"}, 32'(halted), 0);
    check_literal({tag, "_fault"}, 32'(fault), 0);
    check_literal({tag, "_instr_count"}, 32'(instr_count), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply_stimulus(0, 0, 16'h0000, 0, 2'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(0, 0, 16'h0000, 0, 2'd0);
    tick();
    tick();
    check_en = 1'b1;
    check_reset("reset");
    rst = 1'b0;

    // Zero-wait fetch, four sequential stages, then the next fetch.
    apply_stimulus(1, 1, 16'h1042, 0, 2'd0);
    tick();
    check_literal("t1_req_c1", 32'(bus.fetch_req), 1);
    check_literal("t1_valid_c1", 32'(bus.stage_valid), 0);
    for (int s = 0; s < 4; s++) begin
      tick();
      check_literal($sformatf("t1_stage_c%0d", s + 2), 32'(bus.stage), 32'(s));
      check_literal("t1_valid", 32'(bus.stage_valid), 1);
      check_literal("t1_req_low", 32'(bus.fetch_req), 0);
      check_literal("t1_instruction", 32'(bus.instruction), 32'h1042);
    end
    tick();
    check_literal("t1_req_c6", 32'(bus.fetch_req), 1);
    check_literal("t1_valid_c6", 32'(bus.stage_valid), 0);
    check_literal("t1_count_c6", 32'(instr_count), 1);

    // Early completion from stage 1.
    bus.mem_data = 16'h2345;
    tick();
    check_literal("t2_stage0", 32'(bus.stage), 0);
    check_literal("t2_instruction", 32'(bus.instruction), 32'h2345);
    tick();
    check_literal("t2_stage1", 32'(bus.stage), 1);
    bus.next_stage_le = 1'b1;
    bus.next_stage    = 2'd0;
    tick();
    bus.next_stage_le = 1'b0;
    check_literal("t2_retired_valid", 32'(bus.stage_valid), 0);
    check_literal("t2_count", 32'(instr_count), 2);
    check_literal("t2_refetch", 32'(bus.fetch_req), 1);

    // Forward jump, repeated stage, then RUN dropped at stage 2.
    bus.mem_data = 16'h3000;
    tick();
    check_literal("t5_stage0", 32'(bus.stage), 0);
    bus.next_stage_le = 1'b1;
    bus.next_stage    = 2'd2;
    tick();
    check_literal("t5_jump_stage2", 32'(bus.stage), 2);
    tick();
    check_literal("t5_repeat_stage2", 32'(bus.stage), 2);
    bus.next_stage_le = 1'b0;
    run = 1'b0;
    tick();
    check_literal("t5_stage3", 32'(bus.stage), 3);
    tick();
    check_literal("t5_idle_req", 32'(bus.fetch_req), 0);
    check_literal("t5_idle_valid", 32'(bus.stage_valid), 0);
    check_literal("t5_count", 32'(instr_count), 3);
    tick();
    check_literal("t5_idle_hold", 32'(bus.fetch_req), 0);
    run = 1'b1;
    tick();
    check_literal("t5_rerun_req", 32'(bus.fetch_req), 1);

    // Timeout: FAULT four cycles after FETCH_REQ rises.
    bus.mem_ready = 1'b0;
    for (int i = 1; i < TO; i++) begin
      tick();
      check_literal($sformatf("t4_no_fault_%0d", i), 32'(fault), 0);
      check_literal("t4_req_held", 32'(bus.fetch_req), 1);
    end
    tick();
    check_literal("t4_fault", 32'(fault), 1);
    check_literal("t4_fault_req", 32'(bus.fetch_req), 0);
    check_literal("t4_fault_halted", 32'(halted), 0);
    repeat (3) tick();
    check_literal("t4_fault_sticky", 32'(fault), 1);

    // Ready on the last allowed cycle wins over the timeout.
    do_reset();
    apply_stimulus(1, 0, 16'h5A5A, 0, 2'd0);
    tick();
    check_literal("t4b_req", 32'(bus.fetch_req), 1);
    repeat (TO - 1) tick();
    bus.mem_ready = 1'b1;
    tick();
    check_literal("t4b_no_fault", 32'(fault), 0);
    check_literal("t4b_valid", 32'(bus.stage_valid), 1);
    check_literal("t4b_instruction", 32'(bus.instruction), 32'h5A5A);

    // HALT retires after stage 3 and freezes the block until reset.
    do_reset();
    apply_stimulus(1, 1, 16'hF025, 0, 2'd0);
    repeat (5) tick();
    check_literal("t3_stage3", 32'(bus.stage), 3);
    tick();
    check_literal("t3_halted", 32'(halted), 1);
    check_literal("t3_count", 32'(instr_count), 1);
    check_literal("t3_valid", 32'(bus.stage_valid), 0);
    check_literal("t3_fault", 32'(fault), 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_literal("t3_req_quiet", 32'(bus.fetch_req), 0);
    end
    do_reset();
    check_reset("t3_reset");

    // Reset during a stage jump request.
    apply_stimulus(1, 1, 16'h1111, 0, 2'd0);
    repeat (4) tick();
    check_literal("t6_stage2", 32'(bus.stage), 2);
    rst = 1'b1;
    bus.next_stage_le = 1'b1;
    bus.next_stage    = 2'd1;
    tick();
    check_reset("t6_mid_reset");
    rst = 1'b0;
    bus.next_stage_le = 1'b0;

    // Five retires wrap a 2-bit counter to 1.
    apply_stimulus(1, 1, 16'h0001, 0, 2'd0);
    repeat (26) tick();
    check_literal("t6_count_wrap", 32'(instr_count), 1);

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int r;
      int seg;
      int ready_pct;
      r   = $urandom_range(0, 99);
      seg = (i / 250) % 3;
      ready_pct = (seg == 0) ? 75 : ((seg == 1) ? 25 : 50);
      rst = (r < 1) || (m_stopped && r < 8);
      run = ($urandom_range(0, 9) != 0);
      bus.mem_ready     = ($urandom_range(0, 99) < ready_pct);
      bus.mem_data      = ($urandom_range(0, 7) == 0) ? 16'hF025 : 16'($urandom);
      bus.next_stage_le = ($urandom_range(0, 3) == 0);
      bus.next_stage    = 2'($urandom_range(0, 3));
      tick();
    end

    rst = 1'b0;
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
